// File: rtl/bus_arbiter_if.sv
// Request/response bundle shared by each master port and the slave port of the arbiter.
// The initiator drives req/addr/cmd/wdata; the target answers with ack/rdata.
interface bus_arbiter_if;
  logic        req;
  logic [31:0] addr;
  logic        cmd;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, cmd, wdata, input ack, rdata);
  modport slave  (input req, addr, cmd, wdata, output ack, rdata);
endinterface

// File: rtl/bus_arbiter.sv
// Two-master, one-slave bus arbiter with alternating priority and a slave-ack timeout.
// Every transaction returns to IDLE for at least one cycle before the next grant.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_arbiter_if.slave         m0,
  bus_arbiter_if.slave         m1,
  bus_arbiter_if.master        slv,
  output logic [1:0]           grant,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic [7:0]  wcnt_q, wcnt_d;

  logic        own1;
  logic        own_req;
  logic        mst_ack;
  logic [31:0] mst_rdata;

  assign own1    = (state_q == GNT1);
  assign own_req = own1 ? m1.req : m0.req;

  // Only the current owner ever sees an ack or read data.
  assign m0.ack   = mst_ack & (state_q == GNT0);
  assign m0.rdata = (state_q == GNT0) ? mst_rdata : 32'd0;
  assign m1.ack   = mst_ack & own1;
  assign m1.rdata = own1 ? mst_rdata : 32'd0;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    prio_d      = prio_q;
    wcnt_d      = wcnt_q;
    grant       = 2'b00;
    timeout_err = 1'b0;
    mst_ack     = 1'b0;
    mst_rdata   = 32'd0;
    slv.req     = 1'b0;
    slv.addr    = 32'd0;
    slv.cmd     = 1'b0;
    slv.wdata   = 32'd0;

    unique case (state_q)
      IDLE: begin
        wcnt_d = 8'd0;
        if (m0.req && m1.req) state_d = prio_q ? GNT1 : GNT0;
        else if (m0.req)      state_d = GNT0;
        else if (m1.req)      state_d = GNT1;
      end

      GNT0, GNT1: begin
        grant     = own1 ? 2'b10 : 2'b01;
        slv.req   = own_req;
        slv.addr  = own1 ? m1.addr  : m0.addr;
        slv.cmd   = own1 ? m1.cmd   : m0.cmd;
        slv.wdata = own1 ? m1.wdata : m0.wdata;

        if (slv.ack) begin
          // A real ack beats a coincident timeout; priority goes to the other master.
          mst_ack   = 1'b1;
          mst_rdata = slv.rdata;
          state_d   = IDLE;
          prio_d    = ~own1;
          wcnt_d    = 8'd0;
        end else if (!own_req) begin
          state_d = IDLE;
          prio_d  = ~prio_q;
          wcnt_d  = 8'd0;
        end else if (wcnt_q == WCNT_LAST) begin
          mst_ack     = 1'b1;
          timeout_err = 1'b1;
          state_d     = IDLE;
          prio_d      = ~prio_q;
          wcnt_d      = 8'd0;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      wcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, hand-written isolation
// sequence, then randomized traffic against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int unsigned TIMEOUT = 4;
  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] A1 = 32'h0000_0020;
  localparam logic [31:0] W0 = 32'hA0A0_A0A0;
  localparam logic [31:0] W1 = 32'hB1B1_B1B1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       timeout_err;

  bus_arbiter_if m0_bus ();
  bus_arbiter_if m1_bus ();
  bus_arbiter_if slv_bus ();

  bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .m0          (m0_bus.slave),
    .m1          (m1_bus.slave),
    .slv         (slv_bus.master),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  req;     // bit0 = m0, bit1 = m1
    logic        ack;
    logic [31:0] rdata;
    logic [1:0]  g;
    logic [1:0]  ackm;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        te;
    logic        ro;
    logic [31:0] ao;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [1:0] rq, input logic a,
                              input logic [31:0] rd, input logic [1:0] g, input logic [1:0] am,
                              input logic [31:0] r0, input logic [31:0] r1, input logic te,
                              input logic ro, input logic [31:0] ao);
    vec_t v;
    v.rst = r; v.req = rq; v.ack = a; v.rdata = rd; v.g = g; v.ackm = am;
    v.rd0 = r0; v.rd1 = r1; v.te = te; v.ro = ro; v.ao = ao;
    tbl.push_back(v);
  endfunction

  task automatic check_outputs(input string tag, input logic [1:0] g, input logic [1:0] am,
                               input logic [31:0] r0, input logic [31:0] r1, input logic te,
                               input logic ro, input logic [31:0] ao);
    check({tag, " grant"},       32'(grant),          32'(g));
    check({tag, " ack_m0"},      32'(m0_bus.ack),     32'(am[0]));
    check({tag, " ack_m1"},      32'(m1_bus.ack),     32'(am[1]));
    check({tag, " rdata_m0"},    m0_bus.rdata,        r0);
    check({tag, " rdata_m1"},    m1_bus.rdata,        r1);
    check({tag, " timeout_err"}, 32'(timeout_err),    32'(te));
    check({tag, " req_out"},     32'(slv_bus.req),    32'(ro));
    check({tag, " addr_out"},    slv_bus.addr,        ao);
  endtask

  // Reference model state: owner of the bus (-1 = none), priority pointer, cycles waited.
  int owner, prio, waited;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m0_bus.req = 1'b0; m0_bus.addr = A0; m0_bus.cmd = 1'b0; m0_bus.wdata = W0;
    m1_bus.req = 1'b0; m1_bus.addr = A1; m1_bus.cmd = 1'b1; m1_bus.wdata = W1;
    slv_bus.ack = 1'b0; slv_bus.rdata = 32'd0;
    repeat (2) @(negedge clk);

    // ---------------- directed vectors ----------------
    add(1, 2'b00, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0);   // reset state
    add(0, 2'b01, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0);   // single read: latency
    add(0, 2'b01, 0, 32'hDEAD,     2'b01, 2'b00, 0, 0, 0, 1, A0);
    add(0, 2'b01, 1, 32'hCAFE0001, 2'b01, 2'b01, 32'hCAFE0001, 0, 0, 1, A0);
    add(0, 2'b00, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0);
    add(1, 2'b11, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0);   // contention after reset
    add(0, 2'b11, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b11, 1, 1,            2'b01, 2'b01, 1, 0, 0, 1, A0);
    add(0, 2'b11, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b11, 1, 2,            2'b10, 2'b10, 0, 2, 0, 1, A1);
    add(0, 2'b11, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b11, 1, 3,            2'b01, 2'b01, 3, 0, 0, 1, A0);
    add(0, 2'b00, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b10, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0);   // m1 write, slave silent
    for (int k = 0; k < 3; k++)
      add(0, 2'b10, 0, 0,          2'b10, 2'b00, 0, 0, 0, 1, A1);
    add(0, 2'b10, 0, 32'h1234,     2'b10, 2'b10, 0, 0, 1, 1, A1);  // 4th GNT1 cycle: timeout
    add(0, 2'b00, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b10, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0);   // ack coincides with timeout
    for (int k = 0; k < 3; k++)
      add(0, 2'b10, 0, 0,          2'b10, 2'b00, 0, 0, 0, 1, A1);
    add(0, 2'b10, 1, 32'hBEEF,     2'b10, 2'b10, 0, 32'hBEEF, 0, 1, A1);
    add(0, 2'b00, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b01, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0);   // reset mid-transaction
    add(0, 2'b01, 0, 0,            2'b01, 2'b00, 0, 0, 0, 1, A0);
    add(1, 2'b01, 0, 0,            2'b01, 2'b00, 0, 0, 0, 1, A0);
    add(0, 2'b00, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0);
    add(0, 2'b11, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0);   // prio back to 0
    add(0, 2'b11, 1, 5,            2'b01, 2'b01, 5, 0, 0, 1, A0);
    add(0, 2'b10, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0);   // m1 drops req mid-grant
    add(0, 2'b10, 0, 0,            2'b10, 2'b00, 0, 0, 0, 1, A1);
    add(0, 2'b00, 0, 0,            2'b10, 2'b00, 0, 0, 0, 0, A1);
    add(0, 2'b00, 1, 32'hFFFF,     2'b00, 2'b00, 0, 0, 0, 0, 0);   // ack_out in IDLE ignored
    add(0, 2'b11, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0);   // prio flipped to 0
    add(0, 2'b11, 1, 6,            2'b01, 2'b01, 6, 0, 0, 1, A0);
    add(0, 2'b00, 0, 0,            2'b00, 2'b00, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst;
      m0_bus.req = tbl[i].req[0];
      m1_bus.req = tbl[i].req[1];
      slv_bus.ack = tbl[i].ack;
      slv_bus.rdata = tbl[i].rdata;
      #2;
      check_outputs($sformatf("row%0d", i), tbl[i].g, tbl[i].ackm, tbl[i].rd0, tbl[i].rd1,
                    tbl[i].te, tbl[i].ro, tbl[i].ao);
    end

    // ---------------- isolation: m1 and ack_out noise must not leak ----------------
    @(negedge clk);
    m0_bus.req = 1'b1; m1_bus.req = 1'b0;
    slv_bus.ack = 1'b1; slv_bus.rdata = 32'h5555_AAAA;
    #2;
    check_outputs("iso idle", 2'b00, 2'b00, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      slv_bus.ack = 1'b0; slv_bus.rdata = $urandom;
      m1_bus.req = 1'($urandom); m1_bus.addr = $urandom;
      m1_bus.cmd = 1'($urandom); m1_bus.wdata = $urandom;
      #2;
      check_outputs($sformatf("iso gnt%0d", k), 2'b01, 2'b00, 0, 0, 0, 1, A0);
      check("iso cmd_out",   32'(slv_bus.cmd), 32'd0);
      check("iso wdata_out", slv_bus.wdata,    W0);
    end
    @(negedge clk);
    slv_bus.ack = 1'b1; slv_bus.rdata = 32'h7777_0000;
    m1_bus.addr = $urandom; m1_bus.wdata = $urandom;
    #2;
    check_outputs("iso ack", 2'b01, 2'b01, 32'h7777_0000, 0, 0, 1, A0);
    @(negedge clk);
    m0_bus.req = 1'b0; m1_bus.req = 1'b0; slv_bus.ack = 1'b0;

    // ---------------- randomized traffic vs reference model ----------------
    owner = -1; prio = 1; waited = 0;
    begin
      logic        mreq[2];
      logic [31:0] maddr[2], mwdata[2];
      logic        mcmd[2];
      for (int m = 0; m < 2; m++) begin
        mreq[m] = 1'b0; maddr[m] = 0; mwdata[m] = 0; mcmd[m] = 1'b0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
        logic        r, a;
        logic [31:0] rd;
        logic [1:0]  e_g, e_ack;
        logic [31:0] e_rd[2];
        logic        e_te, e_ro, e_cmd;
        logic [31:0] e_ao, e_wd;

        @(negedge clk);
        r  = (cyc == 0) || ($urandom_range(63) == 0);
        a  = ($urandom_range(3) == 0);
        rd = $urandom;
        rst = r; slv_bus.ack = a; slv_bus.rdata = rd;
        m0_bus.req = mreq[0]; m0_bus.addr = maddr[0]; m0_bus.cmd = mcmd[0]; m0_bus.wdata = mwdata[0];
        m1_bus.req = mreq[1]; m1_bus.addr = maddr[1]; m1_bus.cmd = mcmd[1]; m1_bus.wdata = mwdata[1];
        #2;

        e_g = 2'b00; e_ack = 2'b00; e_rd[0] = 0; e_rd[1] = 0;
        e_te = 0; e_ro = 0; e_cmd = 0; e_ao = 0; e_wd = 0;
        if (owner >= 0) begin
          e_g[owner] = 1'b1;
          e_ro = mreq[owner]; e_ao = maddr[owner]; e_cmd = mcmd[owner]; e_wd = mwdata[owner];
          if (a) begin
            e_ack[owner] = 1'b1; e_rd[owner] = rd;
            prio = 1 - owner; owner = -1;
          end else if (!mreq[owner]) begin
            prio = 1 - prio; owner = -1;
          end else if (waited == int'(TIMEOUT) - 1) begin
            e_ack[owner] = 1'b1; e_te = 1'b1;
            prio = 1 - prio; owner = -1;
          end else begin
            waited++;
          end
        end else begin
          waited = 0;
          if (mreq[0] && mreq[1]) owner = prio;
          else if (mreq[0])       owner = 0;
          else if (mreq[1])       owner = 1;
        end
        if (r) begin
          owner = -1; prio = 0; waited = 0;
        end

        check_outputs($sformatf("rnd%0d", cyc), e_g, e_ack, e_rd[0], e_rd[1], e_te, e_ro, e_ao);
        check($sformatf("rnd%0d cmd_out", cyc),   32'(slv_bus.cmd), 32'(e_cmd));
        check($sformatf("rnd%0d wdata_out", cyc), slv_bus.wdata,    e_wd);

        // Masters hold req until acked, occasionally give up, and re-request with fresh fields.
        for (int m = 0; m < 2; m++) begin
          if (e_ack[m]) mreq[m] = 1'b0;
          else if (mreq[m] && $urandom_range(39) == 0) mreq[m] = 1'b0;
          else if (!mreq[m] && $urandom_range(2) == 0) begin
            mreq[m] = 1'b1; maddr[m] = $urandom; mwdata[m] = $urandom; mcmd[m] = 1'($urandom);
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
